// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer:
// frame width, FSM states, peripheral register map and frame packing.
package spi_cfg_pkg;

  localparam int FRAME_W = 16;

  localparam logic [6:0] EN_OUT_7_0  = 7'd0;
  localparam logic [6:0] EN_OUT_15_8 = 7'd1;
  localparam logic [6:0] EN_PWM_7_0  = 7'd2;
  localparam logic [6:0] EN_PWM_15_8 = 7'd3;
  localparam logic [6:0] PWM_DUTY    = 7'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Write frame: write flag, 7-bit address, 8-bit data, sent MSB first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                     input logic [7:0] data);
    return {1'b1, addr, data};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Register-write request channel: valid/ready handshake carrying address and data.
interface spi_cfg_sequencer_if;
  import spi_cfg_pkg::*;

  logic       valid;
  logic       ready;
  logic [6:0] addr;
  logic [7:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/spi_cfg_sequencer_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module spi_cfg_rr_arb
  import spi_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  // Grant decode from the current requests and the last-grant pointer.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Pointer moves on every accept, including dropped requests.
  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = grant_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// SPI write-frame sequencer: arbitrates two requesters and shifts each legal
// request out as a 16-bit frame on ncs/sclk/copi with registered pin outputs.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int ADDR_MAX   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  spi_cfg_sequencer_if.slave        req0,
  spi_cfg_sequencer_if.slave        req1,
  output logic                      ncs,
  output logic                      sclk,
  output logic                      copi,
  output logic                      busy,
  output logic                      done,
  output logic                      err_addr
);

  localparam int              CNT_W    = $clog2(max_int(CLK_DIV, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic               low_q, low_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic ncs_q, sclk_q, copi_q, busy_q, done_q, err_q;
  logic ncs_d, sclk_d, copi_d, busy_d, done_d, err_d;

  logic [1:0] grant_s;
  logic       idle_s, hs_s, legal_s;
  logic [6:0] sel_addr_s;
  logic [7:0] sel_data_s;

  assign idle_s     = (state_q == IDLE);
  assign hs_s       = idle_s && (req0.valid || req1.valid);
  assign sel_addr_s = grant_s[1] ? req1.addr : req0.addr;
  assign sel_data_s = grant_s[1] ? req1.data : req0.data;
  assign legal_s    = ({25'd0, sel_addr_s} <= 32'(ADDR_MAX));

  assign req0.ready = idle_s & grant_s[0];
  assign req1.ready = idle_s & grant_s[1];

  spi_cfg_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({req1.valid, req0.valid}),
    .accept_i (hs_s),
    .grant_o  (grant_s)
  );

  // State, counters and pin registers; reset drops the pins to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      low_q   <= 1'b0;
      sh_q    <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      low_q   <= low_d;
      sh_q    <= sh_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Phase sequencing: each sclk half-period is CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    low_d   = low_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (hs_s && legal_s) begin
          state_d = SETUP;
          cnt_d   = '0;
          bit_d   = 4'd0;
          low_d   = 1'b0;
          sh_d    = build_frame(sel_addr_s, sel_data_s);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!low_q) begin
          // Falling edge: present the next bit, but hold frame[0] through the last low phase.
          cnt_d = '0;
          low_d = 1'b1;
          sh_d  = (bit_q == BIT_LAST) ? sh_q : {sh_q[FRAME_W-2:0], 1'b0};
        end else if (bit_q == BIT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          low_d   = 1'b0;
        end else begin
          cnt_d = '0;
          low_d = 1'b0;
          bit_d = bit_q + 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next pin levels derived from the next state so the pins are registered.
  always_comb begin
    ncs_d  = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d = (state_d == SHIFT) && !low_d;
    copi_d = ncs_d ? 1'b0 : sh_d[FRAME_W-1];
    busy_d = (state_d != IDLE);
    done_d = (state_q == SHIFT) && (state_d == GAP);
    err_d  = hs_s && !legal_s;
  end

  assign ncs      = ncs_q;
  assign sclk     = sclk_q;
  assign copi     = copi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_addr = err_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: frame content and timing, round-robin
// ties, illegal-address drop, continuous streaming and mid-frame reset.
module tb_spi_cfg_sequencer;
  import spi_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ncs, sclk, copi, busy, done, err_addr;

  spi_cfg_sequencer_if req0_if ();
  spi_cfg_sequencer_if req1_if ();

  spi_cfg_sequencer #(.CLK_DIV(4), .GAP_CYCLES(8), .ADDR_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0_if),
    .req1     (req1_if),
    .ncs      (ncs),
    .sclk     (sclk),
    .copi     (copi),
    .busy     (busy),
    .done     (done),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor, sampled on the inactive edge.
  logic        sclk_p = 1'b0;
  logic        ncs_p  = 1'b1;
  logic [15:0] cap;
  int          nrise, low_run;
  int          fall_q[$], rise_q[$], done_q[$], err_q[$], lowcnt_q[$], nrise_q[$];
  logic [15:0] frame_q[$];

  always @(negedge clk) begin
    if (!ncs && ncs_p) begin
      fall_q.push_back(cyc);
      cap = 16'h0000; nrise = 0; low_run = 0;
    end
    if (!ncs) low_run++;
    if (ncs && !ncs_p) begin
      rise_q.push_back(cyc);
      frame_q.push_back(cap);
      lowcnt_q.push_back(low_run);
      nrise_q.push_back(nrise);
    end
    if (sclk && !sclk_p) begin
      cap = {cap[14:0], copi};
      nrise++;
    end
    if (done) done_q.push_back(cyc);
    if (err_addr) err_q.push_back(cyc);
    sclk_p = sclk;
    ncs_p  = ncs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int target);
    for (int n = 0; n < 3000 && cyc < target; n++) tick();
  endtask

  task automatic clr();
    fall_q.delete(); rise_q.delete(); done_q.delete(); err_q.delete();
    lowcnt_q.delete(); nrise_q.delete(); frame_q.delete();
  endtask

  // Wait (bounded) for ready on one requester; returns the handshake cycle.
  task automatic wait_hs(input int which, input bit drop, output int hs_cyc);
    bit got;
    got = 1'b0;
    hs_cyc = -1;
    for (int n = 0; n < 400 && !got; n++) begin
      #1;
      if ((which == 0 && req0_if.ready === 1'b1) || (which == 1 && req1_if.ready === 1'b1)) begin
        hs_cyc = cyc;
        got = 1'b1;
      end
      tick();
      if (got && drop) begin
        if (which == 0) req0_if.valid = 1'b0;
        else            req1_if.valid = 1'b0;
      end
    end
    chk($sformatf("handshake_req%0d", which), 32'(got), 32'd1);
  endtask

  int t, t0, t1;
  int ts[3];

  initial begin
    req0_if.valid = 1'b0; req0_if.addr = 7'd0; req0_if.data = 8'd0;
    req1_if.valid = 1'b0; req1_if.addr = 7'd0; req1_if.data = 8'd0;
    rst = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst_ncs", 32'(ncs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_copi", 32'(copi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_addr), 32'd0);
    chk("rst_ready0", 32'(req0_if.ready), 32'd0);
    chk("rst_ready1", 32'(req1_if.ready), 32'd0);
    rst = 1'b0;
    tick();

    // Single frame: addr 0, data 0xA5
    clr();
    req0_if.addr = EN_OUT_7_0; req0_if.data = 8'hA5; req0_if.valid = 1'b1;
    wait_hs(0, 1'b1, t);
    wait_to(t + 140);
    chk("t1_busy_in_gap", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_after_gap", 32'(busy), 32'd0);
    chk("t1_frame", 32'(frame_q[0]), 32'h80A5);
    chk("t1_sclk_rises", 32'(nrise_q[0]), 32'd16);
    chk("t1_ncs_fall", 32'(fall_q[0] - t), 32'd1);
    chk("t1_ncs_low", 32'(lowcnt_q[0]), 32'd132);
    chk("t1_ncs_rise", 32'(rise_q[0] - t), 32'd133);
    chk("t1_done_count", 32'(done_q.size()), 32'd1);
    chk("t1_done_cycle", 32'(done_q[0] - t), 32'd133);

    // Tie from reset: req0 first, req1 second
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    clr();
    req0_if.addr = EN_PWM_7_0;  req0_if.data = 8'h0F; req0_if.valid = 1'b1;
    req1_if.addr = EN_PWM_15_8; req1_if.data = 8'hF0; req1_if.valid = 1'b1;
    #1;
    chk("t2_tie_ready0", 32'(req0_if.ready), 32'd1);
    chk("t2_tie_ready1", 32'(req1_if.ready), 32'd0);
    wait_hs(0, 1'b1, t0);
    wait_hs(1, 1'b1, t1);
    wait_to(t1 + 135);
    chk("t2_frame0", 32'(frame_q[0]), 32'h820F);
    chk("t2_frame1", 32'(frame_q[1]), 32'h83F0);
    chk("t2_hs_spacing", 32'(t1 - t0), 32'd141);
    chk("t2_ncs_high_gap", 32'(fall_q[1] - rise_q[0]), 32'd9);

    // req0 held valid with three payloads; payload garbage while busy
    clr();
    req0_if.addr = EN_PWM_7_0; req0_if.data = 8'h11; req0_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_hs(0, 1'b0, ts[i]);
      if (i == 2) begin
        req0_if.valid = 1'b0;
      end else begin
        req0_if.addr = 7'h55; req0_if.data = 8'hEE;
        wait_to(ts[i] + 60);
        req0_if.addr = (i == 0) ? EN_PWM_15_8 : PWM_DUTY;
        req0_if.data = (i == 0) ? 8'h22 : 8'h33;
      end
    end
    wait_to(ts[2] + 142);
    chk("t4_spacing01", 32'(ts[1] - ts[0]), 32'd141);
    chk("t4_spacing12", 32'(ts[2] - ts[1]), 32'd141);
    chk("t4_start_spacing", 32'(fall_q[2] - fall_q[1]), 32'd141);
    chk("t4_frame0", 32'(frame_q[0]), 32'h8211);
    chk("t4_frame1", 32'(frame_q[1]), 32'h8322);
    chk("t4_frame2", 32'(frame_q[2]), 32'h8433);
    chk("t4_done_count", 32'(done_q.size()), 32'd3);

    // Illegal address on req1 is dropped; pointer still moves
    clr();
    req1_if.addr = 7'd5; req1_if.data = 8'hFF; req1_if.valid = 1'b1;
    wait_hs(1, 1'b1, t);
    wait_to(t + 6);
    chk("t3_err_count", 32'(err_q.size()), 32'd1);
    chk("t3_err_cycle", 32'(err_q[0] - t), 32'd1);
    chk("t3_no_frame", 32'(fall_q.size()), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_ncs", 32'(ncs), 32'd1);
    req0_if.addr = EN_OUT_15_8; req0_if.valid = 1'b1;
    req1_if.addr = EN_OUT_15_8; req1_if.valid = 1'b1;
    #1;
    chk("t3_tie_ready0", 32'(req0_if.ready), 32'd1);
    chk("t3_tie_ready1", 32'(req1_if.ready), 32'd0);
    req0_if.valid = 1'b0; req1_if.valid = 1'b0;
    tick();

    // Reset during bit 7, then a full frame
    clr();
    req0_if.addr = EN_OUT_15_8; req0_if.data = 8'h5A; req0_if.valid = 1'b1;
    wait_hs(0, 1'b1, t);
    wait_to(t + 62);
    chk("t5_bit7_ncs", 32'(ncs), 32'd0);
    chk("t5_bit7_sclk", 32'(sclk), 32'd1);
    chk("t5_bit7_copi", 32'(copi), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ncs", 32'(ncs), 32'd1);
    chk("t5_rst_sclk", 32'(sclk), 32'd0);
    chk("t5_rst_copi", 32'(copi), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t5_no_done", 32'(done_q.size()), 32'd0);
    clr();
    req0_if.addr = PWM_DUTY; req0_if.data = 8'h80; req0_if.valid = 1'b1;
    wait_hs(0, 1'b1, t);
    wait_to(t + 135);
    chk("t5_frame", 32'(frame_q[0]), 32'h8480);
    chk("t5_ncs_low", 32'(lowcnt_q[0]), 32'd132);
    chk("t5_done_cycle", 32'(done_q[0] - t), 32'd133);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cfg_sequencer.md
# spi_cfg_sequencer

SPI master-side configuration sequencer that drives the ncs/sclk/copi pins of the SPI register peripheral. It accepts register-write requests from two independent requesters, arbitrates between them round-robin, and serialises each accepted request into one 16-bit write frame. Frame timing is slow enough for the peripheral's 2-FF input synchronisers. It sits between on-chip configuration agents (boot loader, host bridge) and the SPI pins.

## Interface

Clocking and reset (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles; legal range ≥ 2.
- GAP_CYCLES, 8: ncs-high idle time between frames, in clk cycles; legal range ≥ 1.
- ADDR_MAX, 4: highest legal register address.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has a write pending
- req0_ready  out  1  requester 0 accepted this cycle
- req0_addr  in  7  requester 0 register address
- req0_data  in  8  requester 0 write data
- req1_valid / req1_ready / req1_addr / req1_data: same as requester 0, for requester 1
- ncs  out  1  SPI chip select, active-low
- sclk  out  1  SPI clock, idle low
- copi  out  1  SPI serial data, MSB first
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a frame completes
- err_addr  out  1  one-cycle pulse when a request is dropped for address > ADDR_MAX

## Operation

- Frame format: {1'b1 (write), addr[6:0], data[7:0]}, sent MSB first. The peripheral samples copi on sclk rising edges.
- State machine: IDLE → SETUP → SHIFT → GAP → IDLE.
- IDLE:
  - Pin levels: ncs=1, sclk=0, copi=0.
  - req*_ready is combinational. It is high only for the requester granted this cycle, and only in IDLE.
  - Handshake occurs when valid && ready.
- Arbitration:
  - Round-robin. If both requesters are valid, the one not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates on every handshake, including dropped requests.
- Illegal address (addr > ADDR_MAX):
  - The handshake still completes.
  - No frame is sent; err_addr pulses the next cycle.
  - The block stays in IDLE.
- Legal address: the frame is latched at the handshake and the block enters SETUP.
- SETUP:
  - Lasts CLK_DIV cycles.
  - ncs=0, sclk=0, copi=frame[15].
- SHIFT: 16 bits, each bit = CLK_DIV cycles sclk=1, then CLK_DIV cycles sclk=0.
  - copi updates to the next bit in the same cycle sclk falls.
  - The low phase of bit 0 serves as ncs hold time; copi holds frame[0] during it.
- GAP:
  - Lasts GAP_CYCLES cycles with ncs=1, sclk=0, copi=0.
  - done pulses in the first GAP cycle.
- Input changes while busy are ignored. Requesters must hold valid and payload until ready is seen.

## Timing

- Reset values: ncs=1, sclk=0, copi=0, busy=0, done=0, err_addr=0, req*_ready=0. State=IDLE, last-grant=1.
- Outputs are registered except req*_ready.
- Handshake in cycle T:
  - ncs falls at T+1.
  - ncs is low for 33·CLK_DIV cycles (132 at default).
  - ncs rises and done pulses at T+1+33·CLK_DIV.
  - The earliest next handshake is at T+1+33·CLK_DIV+GAP_CYCLES.
- Back-to-back throughput: one frame per 33·CLK_DIV+GAP_CYCLES+1 cycles.
- Bit/cycle counters must be wide enough for max(CLK_DIV, GAP_CYCLES) and for 16 bits. No wrap-around is permitted within a phase.
- Reset mid-frame:
  - All pins return to idle immediately (asynchronous) and no done pulse is generated.
  - The resulting ncs rise causes the peripheral to commit a partial frame. Mid-frame reset is therefore a system-level hazard, documented here and not masked by this block.

## Structure

- Shared package spi_cfg_pkg holds:
  - FRAME_W=16;
  - the state enum (IDLE, SETUP, SHIFT, GAP);
  - register address constants: EN_OUT_7_0=0, EN_OUT_15_8=1, EN_PWM_7_0=2, EN_PWM_15_8=3, PWM_DUTY=4.
- One sub-module, spi_cfg_rr_arb: a 2-way round-robin arbiter (valid in, grant out, pointer update on accept).
- Everything else (FSM, shift register, divider counter) lives in spi_cfg_sequencer.

## Test plan

- req0 addr=0 data=0xA5, default parameters → copi over 16 sclk rises = 1,0000000,10100101; ncs low exactly 132 cycles; done one pulse; busy low after GAP.
- req0 and req1 valid in the same cycle from reset (addr 2/0x0F, addr 3/0xF0) → req0 framed first, req1 second; frames separated by exactly 8 ncs-high cycles plus the 1-cycle IDLE accept.
- req1 addr=5 data=0xFF → req1_ready handshake; err_addr pulses once at T+1; ncs stays 1; busy stays 0; next tie grants req0.
- req0 held valid continuously with 3 payloads → 3 frames, each start 141 cycles apart; payload changes while busy are not sampled.
- rst asserted at bit 7 of a frame → ncs=1, sclk=0, copi=0 in the same cycle; no done; after release, a new request completes a full correct frame.
- Loopback with the SPI peripheral (its rst_n = ~rst): write addr=4 data=0x80 → pwm_duty_cycle=0x80 within 10 clk of ncs rise.
